// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial-SRAM responder (READ/WRITE/RDSR/WRSR, sequential) over an on-chip byte array, pins oversampled on HCLK.
// Pin edges act 3 HCLK after the pin, MISO within 4 HCLK of SCLK fall; no backpressure, the master paces everything (SCLK <= HCLK/8).
module spi_sram_responder #(
    parameter int          ADDR_W     = 8,
    parameter logic [7:0]  STATUS_VAL = 8'h40
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic SCLK,
    input  logic SSn,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_oe,
    output logic wr_stb,
    output logic cmd_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RD, ST_WR, ST_RDSR, ST_WRSR, ST_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        mem [0:DEPTH-1];
    logic              sclk_s1, sclk_s2, sclk_s3;
    logic              ssn_s1, ssn_s2, ssn_s3;
    logic              mosi_s1, mosi_s2;
    logic [1:0]        pipe_cnt;
    logic              armed;
    logic [2:0]        bit_cnt;
    logic              addr_byte;
    logic              is_rd;
    logic [7:0]        sh_in;
    logic [7:0]        sh_out;
    logic              miso_q;
    logic [ADDR_W-1:0] addr;
    logic              wr_stb_q, cmd_err_q, cmd_err_d;

    logic              sclk_rise, sclk_fall, ssn_fall, ssn_rise;
    logic              rise_act, fall_act, byte_done;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_nxt, addr_inc;
    logic              mem_we;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ssn_fall  = ~ssn_s2 & ssn_s3;
    assign ssn_rise  = ssn_s2 & ~ssn_s3;
    assign rise_act  = sclk_rise & ~ssn_s2;
    assign fall_act  = sclk_fall & ~ssn_s2;
    assign byte_done = (bit_cnt == 3'd7);
    assign byte_in   = {sh_in[6:0], mosi_s2};
    assign addr_nxt  = {addr[ADDR_W-2:0], mosi_s2};
    assign addr_inc  = addr + ADDR_W'(1);
    assign mem_we    = ~HRESET && (state_q == ST_WR) && rise_act && byte_done;

    // Next state and command decode
    always_comb begin
        state_d   = state_q;
        cmd_err_d = 1'b0;
        if (ssn_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (ssn_fall && armed) state_d = ST_CMD;
                ST_CMD: begin
                    if (rise_act && byte_done) begin
                        case (byte_in)
                            8'h03, 8'h02: state_d = ST_ADDR;
                            8'h05:        state_d = ST_RDSR;
                            8'h01:        state_d = ST_WRSR;
                            default: begin
                                state_d   = ST_IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: if (rise_act && byte_done && addr_byte) state_d = is_rd ? ST_RD : ST_WR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // After reset the SSn pin may still be low mid-frame; only a genuinely
    // observed high level re-arms frame detection.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sclk_s1  <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            ssn_s1   <= 1'b1; ssn_s2  <= 1'b1; ssn_s3  <= 1'b1;
            mosi_s1  <= 1'b0; mosi_s2 <= 1'b0;
            pipe_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            sclk_s1 <= SCLK;    sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            ssn_s1  <= SSn;     ssn_s2  <= ssn_s1;  ssn_s3  <= ssn_s2;
            mosi_s1 <= MOSI;    mosi_s2 <= mosi_s1;
            if (pipe_cnt != 2'd3) pipe_cnt <= pipe_cnt + 2'd1;
            if (pipe_cnt == 2'd3 && ssn_s2 && ssn_s3) armed <= 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bit_cnt   <= 3'd0;
            addr_byte <= 1'b0;
            is_rd     <= 1'b0;
            sh_in     <= 8'h00;
            sh_out    <= 8'h00;
            miso_q    <= 1'b0;
            addr      <= '0;
            wr_stb_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            wr_stb_q  <= 1'b0;
            cmd_err_q <= cmd_err_d;

            if (state_q == ST_IDLE)  bit_cnt <= 3'd0;
            else if (rise_act)       bit_cnt <= bit_cnt + 3'd1;

            if (state_q != ST_ADDR)            addr_byte <= 1'b0;
            else if (rise_act && byte_done)    addr_byte <= 1'b1;

            if (state_q != ST_IDLE && rise_act) sh_in <= byte_in;
            if (state_q == ST_IDLE)             miso_q <= 1'b0;

            case (state_q)
                ST_CMD: begin
                    if (rise_act && byte_done) begin
                        is_rd <= (byte_in == 8'h03);
                        if (byte_in == 8'h05) sh_out <= STATUS_VAL;
                    end
                end
                ST_ADDR: begin
                    if (rise_act) begin
                        addr <= addr_nxt;
                        if (byte_done && addr_byte && is_rd) sh_out <= mem[addr_nxt];
                    end
                end
                ST_RD: begin
                    if (rise_act && byte_done) begin
                        addr   <= addr_inc;
                        sh_out <= mem[addr_inc];
                    end else if (fall_act) begin
                        miso_q <= sh_out[7];
                        sh_out <= {sh_out[6:0], 1'b0};
                    end
                end
                ST_RDSR: begin
                    if (rise_act && byte_done) begin
                        sh_out <= STATUS_VAL;
                    end else if (fall_act) begin
                        miso_q <= sh_out[7];
                        sh_out <= {sh_out[6:0], 1'b0};
                    end
                end
                ST_WR: begin
                    if (rise_act && byte_done) begin
                        addr     <= addr_inc;
                        wr_stb_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array contents deliberately survive HRESET
    always_ff @(posedge HCLK) begin
        if (mem_we) mem[addr] <= byte_in;
    end

    assign MISO_oe = (state_q == ST_RD) || (state_q == ST_RDSR);
    assign MISO    = MISO_oe & miso_q;
    assign wr_stb  = wr_stb_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: an SPI mode-0 master drives frames, MISO bytes and pulse counts are checked against hand-computed values.
module tb_spi_sram_responder;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic SCLK = 1'b0;
    logic SSn = 1'b1;
    logic MOSI = 1'b0;
    logic MISO, MISO_oe, wr_stb, cmd_err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int oe_cnt = 0;

    spi_sram_responder #(.ADDR_W(8), .STATUS_VAL(8'h40)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .SCLK(SCLK), .SSn(SSn), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .wr_stb(wr_stb), .cmd_err(cmd_err)
    );

    always #5 HCLK = ~HCLK;

    // Free-running pulse counters; tests take differences
    always @(negedge HCLK) begin
        if (wr_stb)  wr_cnt  <= wr_cnt + 1;
        if (cmd_err) err_cnt <= err_cnt + 1;
        if (MISO_oe) oe_cnt  <= oe_cnt + 1;
    end

    task automatic spi_bit(input logic b, output logic r);
        MOSI = b;
        #50;
        r = MISO;
        SCLK = 1'b1;
        #50;
        SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic frame_start();
        SSn = 1'b0;
        #50;
    endtask

    task automatic frame_end();
        #50;
        SSn = 1'b1;
        #100;
    endtask

    task automatic write2(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] rx;
        frame_start();
        spi_byte(8'h02, rx); spi_byte(a[15:8], rx); spi_byte(a[7:0], rx);
        spi_byte(d0, rx); spi_byte(d1, rx);
        frame_end();
    endtask

    task automatic read2(input logic [15:0] a, output logic [7:0] r0, output logic [7:0] r1);
        logic [7:0] rx;
        frame_start();
        spi_byte(8'h03, rx); spi_byte(a[15:8], rx); spi_byte(a[7:0], rx);
        spi_byte(8'h00, r0); spi_byte(8'h00, r1);
        frame_end();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (4) @(negedge HCLK);
        checks++; if (MISO !== 1'b0)    begin errors++; $display("FAIL reset_miso got=%b exp=0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", MISO_oe); end
        checks++; if (wr_stb !== 1'b0)  begin errors++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        HRESET = 1'b0;
        repeat (10) @(negedge HCLK);
    endtask

    task automatic test_write_read();
        logic [7:0] r0, r1;
        int base;
        base = wr_cnt;
        write2(16'h0010, 8'hA5, 8'h5A);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL wr_stb_count got=%0d exp=2", wr_cnt - base); end
        read2(16'h0010, r0, r1);
        checks++; if (r0 !== 8'hA5) begin errors++; $display("FAIL read_byte0 got=%h exp=a5", r0); end
        checks++; if (r1 !== 8'h5A) begin errors++; $display("FAIL read_byte1 got=%h exp=5a", r1); end
    endtask

    task automatic test_wrap();
        logic [7:0] r0, r1;
        int base;
        base = wr_cnt;
        write2(16'h12FF, 8'h11, 8'h22);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL wrap_wr_count got=%0d exp=2", wr_cnt - base); end
        read2(16'h0000, r0, r1);
        checks++; if (r0 !== 8'h22) begin errors++; $display("FAIL wrap_read_00 got=%h exp=22", r0); end
        read2(16'h00FF, r0, r1);
        checks++; if (r0 !== 8'h11) begin errors++; $display("FAIL wrap_read_ff got=%h exp=11", r0); end
        checks++; if (r1 !== 8'h22) begin errors++; $display("FAIL wrap_read_rollover got=%h exp=22", r1); end
    endtask

    task automatic test_status();
        logic [7:0] rx, s0, s1, r0, r1;
        int wbase, ebase;
        frame_start();
        spi_byte(8'h05, rx); spi_byte(8'h00, s0); spi_byte(8'h00, s1);
        frame_end();
        checks++; if (s0 !== 8'h40) begin errors++; $display("FAIL rdsr_byte0 got=%h exp=40", s0); end
        checks++; if (s1 !== 8'h40) begin errors++; $display("FAIL rdsr_byte1 got=%h exp=40", s1); end
        wbase = wr_cnt;
        ebase = err_cnt;
        frame_start();
        spi_byte(8'h01, rx); spi_byte(8'h00, rx);
        frame_end();
        checks++; if (wr_cnt - wbase !== 0)  begin errors++; $display("FAIL wrsr_wr_stb got=%0d exp=0", wr_cnt - wbase); end
        checks++; if (err_cnt - ebase !== 0) begin errors++; $display("FAIL wrsr_cmd_err got=%0d exp=0", err_cnt - ebase); end
        read2(16'h0010, r0, r1);
        checks++; if (r0 !== 8'hA5) begin errors++; $display("FAIL wrsr_mem_kept got=%h exp=a5", r0); end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] rx, acc;
        int wbase, ebase, obase;
        wbase = wr_cnt; ebase = err_cnt; obase = oe_cnt;
        acc = 8'h00;
        frame_start();
        spi_byte(8'h9F, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'hFF, rx);
            acc = acc | rx;
        end
        frame_end();
        checks++; if (err_cnt - ebase !== 1) begin errors++; $display("FAIL bad_cmd_err got=%0d exp=1", err_cnt - ebase); end
        checks++; if (oe_cnt - obase !== 0)  begin errors++; $display("FAIL bad_miso_oe got=%0d exp=0", oe_cnt - obase); end
        checks++; if (wr_cnt - wbase !== 0)  begin errors++; $display("FAIL bad_wr_stb got=%0d exp=0", wr_cnt - wbase); end
        checks++; if (acc !== 8'h00)         begin errors++; $display("FAIL bad_miso_data got=%h exp=00", acc); end
    endtask

    task automatic test_abort();
        logic [7:0] rx, r0, r1;
        logic r;
        int base;
        write2(16'h0020, 8'h3C, 8'hC3);
        base = wr_cnt;
        frame_start();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
        frame_end();
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL abort_wr_stb got=%0d exp=0", wr_cnt - base); end
        read2(16'h0020, r0, r1);
        checks++; if (r0 !== 8'h3C) begin errors++; $display("FAIL abort_mem_kept got=%h exp=3c", r0); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, r0, r1;
        logic r;
        int obase;
        write2(16'h0030, 8'h77, 8'h88);
        frame_start();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h30, rx);
        spi_byte(8'h00, r0);
        checks++; if (r0 !== 8'h77) begin errors++; $display("FAIL midrst_byte0 got=%h exp=77", r0); end
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        checks++; if (MISO !== 1'b0)    begin errors++; $display("FAIL midrst_miso got=%b exp=0", MISO); end
        checks++; if (MISO_oe !== 1'b0) begin errors++; $display("FAIL midrst_oe got=%b exp=0", MISO_oe); end
        obase = oe_cnt;
        for (int i = 0; i < 13; i++) spi_bit(1'b0, r);
        frame_end();
        checks++; if (oe_cnt - obase !== 0) begin errors++; $display("FAIL midrst_ignored got=%0d exp=0", oe_cnt - obase); end
        read2(16'h0030, r0, r1);
        checks++; if (r0 !== 8'h77) begin errors++; $display("FAIL midrst_reread0 got=%h exp=77", r0); end
        checks++; if (r1 !== 8'h88) begin errors++; $display("FAIL midrst_reread1 got=%h exp=88", r1); end
    endtask

    initial begin
        @(negedge HCLK);
        test_reset();
        test_write_read();
        test_wrap();
        test_status();
        test_bad_opcode();
        test_abort();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_sram_responder.md
# spi_sram_responder

Synthesizable SPI mode-0 responder that emulates a 23LC512-style serial SRAM (READ/WRITE/RDSR/WRSR, sequential mode) behind a small on-chip byte array. It is the target end of the SoC's SPI master interface (MSI/MSO/SSn/SCLK). It replaces the behavioural SRAM model in FPGA and gate-level regressions, and can also serve as a loopback target on a second die. All SPI pins are oversampled in the HCLK domain; there is no SCLK-clocked logic.

## Interface
- ADDR_W, 8: implemented address bits; memory depth = 2^ADDR_W bytes. Upper bits of the 16-bit SPI address are ignored.
- STATUS_VAL, 8'h40: byte returned by RDSR (sequential mode).
- HCLK  input  1  system clock; all logic on its rising edge.
- HRESET  input  1  reset, synchronous, active-high.
- SCLK  input  1  SPI clock from master, asynchronous to HCLK; idles low (mode 0).
- SSn  input  1  chip select, active-low, asynchronous.
- MOSI  input  1  master-out serial data (master's MSO).
- MISO  output  1  serial data to master (master's MSI); 0 when not driving.
- MISO_oe  output  1  MISO output enable for pad tristate.
- wr_stb  output  1  one-cycle pulse when a byte is committed to memory.
- cmd_err  output  1  one-cycle pulse when an unsupported opcode is received.

## Operation
- Input sync: SCLK, SSn and MOSI each pass through 2 flops, plus a third flop for edge detect. rise = s2 & ~s3; fall = ~s2 & s3. MOSI is sampled from its synced value on rise. All protocol logic is gated by synced SSn low.
- Framing: MSB first; 8-bit opcode, then 16-bit address (reads/writes only), then data. A 3-bit bit counter resets to 0 on every synced SSn fall.
- FSM states: IDLE, CMD, ADDR, RD, WR, RDSR, WRSR, IGNORE.
  - IDLE -> CMD on synced SSn fall.
  - CMD after the 8th rise, by opcode: 0x03 -> ADDR(rd); 0x02 -> ADDR(wr); 0x05 -> RDSR; 0x01 -> WRSR; anything else -> IGNORE, with cmd_err pulsed.
  - ADDR after 16 rises -> RD or WR. The address register takes addr[ADDR_W-1:0].
  - Any state -> IDLE on synced SSn rise. A partial byte is discarded with no write.
- RD: on the rise that completes the address, load mem[addr] into the shift-out register. On each following fall, shift the next bit onto MISO, so MSB appears at the first fall. On every 8th data rise, addr <= addr+1 (mod 2^ADDR_W) and reload from the new addr. Read runs indefinitely, wrapping around the array.
- WR: after each 8th data rise, mem[addr] <= shifted byte, wr_stb = 1 for one cycle, addr <= addr+1 (mod 2^ADDR_W). Wraps indefinitely.
- RDSR: shifts STATUS_VAL repeatedly, loaded on the opcode-completing rise.
- WRSR: accepts and discards the data byte(s); no state change.
- IGNORE: MISO_oe stays 0 until SSn rises.
- MISO_oe = 1 only in RD and RDSR; MISO = 0 whenever MISO_oe = 0.
- Memory contents are not reset and survive HRESET.

## Timing
- Reset values: MISO=0, MISO_oe=0, wr_stb=0, cmd_err=0, state=IDLE, bit counter=0, addr=0, sync flops=idle values (SCLK 0, SSn 1).
- Pin-to-detect latency: a pin edge is seen as rise/fall 3 HCLK later. MISO updates on the HCLK edge after the fall is detected, i.e. ≤4 HCLK after the SCLK fall at the pin.
- Constraint: SCLK high and low phases ≥ 4 HCLK each (SCLK ≤ HCLK/8). SSn setup to the first SCLK rise ≥ 4 HCLK.
- wr_stb and the memory write occur on the same HCLK edge, the cycle after the 8th rise is detected.
- cmd_err pulses the cycle after the 8th opcode rise is detected.
- MISO_oe rises on the cycle RD/RDSR is entered and falls the cycle after synced SSn rises.
- HRESET mid-transfer: IDLE and all outputs 0 on the next HCLK edge. The rest of the frame is ignored until SSn goes high and then low again.

## Test plan
- Write/read: write 02 00 10 A5 5A, SSn high; read 03 00 10 plus 16 clocks -> MISO returns A5 5A; wr_stb pulses exactly twice.
- Wrap (ADDR_W=8): write 02 12 FF 11 22; read 03 00 00 -> 22; read 03 00 FF -> 11 (high address byte 0x12 ignored).
- Status: 05 plus 16 clocks -> 40 40; WRSR 01 00 -> no wr_stb, no cmd_err, memory unchanged.
- Bad opcode: 9F plus 24 clocks -> cmd_err one pulse, MISO_oe = 0 throughout, no wr_stb.
- Abort: 02 00 20 then 5 data bits, SSn high -> no wr_stb; read of 0x20 returns the prior value.
- Reset mid-read: assert HRESET during the 2nd data byte of a READ -> MISO = MISO_oe = 0 the next cycle. A new frame after SSn toggles reads correct data, showing memory is preserved.
